// File: rtl/fp_normalize_round_pkg.sv
// rtl/fp_normalize_round_pkg.sv - widths, limits and FSM encoding shared by the normalise/round stage.
package fp_normalize_round_pkg;

  localparam int MAG_W = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  localparam logic [EXP_W-1:0] E_MAX   = 3'd7;
  localparam logic [EXP_W-1:0] E_ONE   = 3'd1;
  localparam logic [SIG_W-1:0] F_MAX   = 4'hF;
  localparam logic [SIG_W-1:0] F_CARRY = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_normalize_round_round_unit.sv
// rtl/fp_normalize_round_round_unit.sv - combinational exponent/significand from shift count and top bits.
// FPCVT_ROUND_EN selects round half-up on rb; otherwise the significand is truncated.
module fp_normalize_round_round_unit
  import fp_normalize_round_pkg::*;
(
  input  logic [SIG_W-1:0] fraw,
  input  logic             rb,
  input  logic [EXP_W-1:0] k,
  input  logic             sat,
  output logic [EXP_W-1:0] e,
  output logic [SIG_W-1:0] f
);

  logic [EXP_W-1:0] eraw;
  assign eraw = E_MAX - k;

`ifdef FPCVT_ROUND_EN
  logic [SIG_W:0] sum;
  assign sum = {1'b0, fraw} + {{SIG_W{1'b0}}, rb};

  // The carry is resolved before touching E so an overflowing exponent saturates instead of wrapping.
  always_comb begin
    e = eraw;
    f = sum[SIG_W-1:0];
    if (sat || (sum[SIG_W] && (eraw == E_MAX))) begin
      e = E_MAX;
      f = F_MAX;
    end else if (sum[SIG_W]) begin
      e = eraw + E_ONE;
      f = F_CARRY;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = rb;

  always_comb begin
    e = eraw;
    f = fraw;
    if (sat) begin
      e = E_MAX;
      f = F_MAX;
    end
  end
`endif

endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - sign/magnitude to S|E|F code: one-bit-per-cycle normalise, then round.
// Rounding mode is selected by FPCVT_ROUND_EN (see round unit); latency is the same either way.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic [MAG_W-1:0] r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F
);

  state_t           state, state_nxt;
  logic [MAG_W-1:0] m;
  logic [EXP_W-1:0] k;
  logic             sign;
  logic             shift_go;
  logic [EXP_W-1:0] e_rnd;
  logic [SIG_W-1:0] f_rnd;
  logic             unused_m;

  assign unused_m = ^m[5:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift_go  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SHIFT;
      end
      // m[11] only arises for r=2048, which bypasses shifting and saturates.
      ST_SHIFT: begin
        if (m[11] || m[10] || (k == E_MAX)) state_nxt = ST_ROUND;
        else                                 shift_go  = 1'b1;
      end
      ST_ROUND: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  fp_normalize_round_round_unit u_round (
    .fraw (m[10:7]),
    .rb   (m[6]),
    .k    (k),
    .sat  (m[11]),
    .e    (e_rnd),
    .f    (f_rnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m    <= '0;
      k    <= '0;
      sign <= 1'b0;
      S    <= 1'b0;
      E    <= '0;
      F    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            m    <= r;
            k    <= '0;
            sign <= s;
          end
        end
        ST_SHIFT: begin
          if (shift_go) begin
            m <= {m[MAG_W-2:0], 1'b0};
            k <= k + E_ONE;
          end
        end
        ST_ROUND: begin
          S <= sign;
          E <= e_rnd;
          F <= f_rnd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed vector bench for fp_normalize_round (expectations follow FPCVT_ROUND_EN).
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [11:0] r;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F)
  );

  typedef struct {
    logic        s;
    logic [11:0] r;
    int          lat;
    logic        es;
    logic [2:0]  e;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_op(input logic sv, input logic [11:0] rv);
    in_valid = 1'b1;
    s        = sv;
    r        = rv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s        = 1'b0;
    r        = '0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int    lat;
    string tag;
    tag = $sformatf("r=%0d s=%0d", v.r, v.s);
    start_op(v.s, v.r);
    wait_valid(lat);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " S"}, S, v.es);
    check({tag, " E"}, E, v.e);
    check({tag, " F"}, F, v.f);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after accept"}, out_valid, 0);
    check({tag, " in_ready after accept"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s         = 1'b0;
    r         = '0;

    vecs.push_back('{1'b0, 12'd44,   7, 1'b0, 3'd2, 4'b1011});
    vecs.push_back('{1'b0, 12'd2047, 2, 1'b0, 3'd7, 4'b1111});
    vecs.push_back('{1'b1, 12'd2048, 2, 1'b1, 3'd7, 4'b1111});
    vecs.push_back('{1'b0, 12'd0,    9, 1'b0, 3'd0, 4'b0000});
    vecs.push_back('{1'b0, 12'd13,   9, 1'b0, 3'd0, 4'b1101});
    vecs.push_back('{1'b0, 12'd1024, 2, 1'b0, 3'd7, 4'b1000});
    vecs.push_back('{1'b0, 12'd1,    9, 1'b0, 3'd0, 4'b0001});
    vecs.push_back('{1'b1, 12'd3,    9, 1'b1, 3'd0, 4'b0011});
`ifdef FPCVT_ROUND_EN
    vecs.push_back('{1'b0, 12'd46,   7, 1'b0, 3'd2, 4'b1100});
    vecs.push_back('{1'b0, 12'd125,  6, 1'b0, 3'd4, 4'b1000});
    vecs.push_back('{1'b1, 12'd100,  6, 1'b1, 3'd3, 4'b1101});
`else
    vecs.push_back('{1'b0, 12'd46,   7, 1'b0, 3'd2, 4'b1011});
    vecs.push_back('{1'b0, 12'd125,  6, 1'b0, 3'd3, 4'b1111});
    vecs.push_back('{1'b1, 12'd100,  6, 1'b1, 3'd3, 4'b1100});
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset S", S, 0);
    check("reset E", E, 0);
    check("reset F", F, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hold off the consumer with in_valid asserted: outputs must not move.
    start_op(1'b1, 12'd46);
    wait_valid(lat);
    check("hold latency", lat, 7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      r        = 12'd13;
      @(posedge clk); #1;
      check($sformatf("hold%0d out_valid", i), out_valid, 1);
      check($sformatf("hold%0d in_ready", i), in_ready, 0);
      check($sformatf("hold%0d S", i), S, 1);
      check($sformatf("hold%0d E", i), E, 2);
`ifdef FPCVT_ROUND_EN
      check($sformatf("hold%0d F", i), F, 4'b1100);
`else
      check($sformatf("hold%0d F", i), F, 4'b1011);
`endif
    end
    in_valid  = 1'b0;
    r         = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold release out_valid", out_valid, 0);

    // Reset mid-shift aborts and clears the registered outputs.
    start_op(1'b0, 12'd0);
    @(posedge clk); #1;
    check("shift in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort S", S, 0);
    check("abort E", E, 0);
    check("abort F", F, 0);
    rst = 1'b0;

    run_vec('{1'b0, 12'd44, 7, 1'b0, 3'd2, 4'b1011});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
